// File: rtl/max_pool_2x2_stream.sv
// 2x2 stride-2 max pooling over a raster-order pixel stream.
// Even rows leave one horizontal pair maximum per window in a half-width line buffer.
// Odd rows combine their pair maximum with that entry and emit one pooled pixel.
module max_pool_2x2_stream #(
    parameter int IMG_Width  = 4,
    parameter int IMG_Height = 4,
    parameter int Datawidth  = 32,
    parameter bit SIGNED     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [Datawidth-1:0] In,
    output logic                 valid_out,
    output logic [Datawidth-1:0] Out,
    output logic                 frame_done
);

    localparam int HalfW = IMG_Width / 2;
    localparam int ColW  = $clog2(IMG_Width);
    localparam int RowW  = $clog2(IMG_Height);
    localparam int IdxW  = (ColW > 1) ? ColW - 1 : 1;

    // Reject frame geometries that cannot be tiled by 2x2 windows.
    if ((IMG_Width < 2) || ((IMG_Width % 2) != 0)) begin : g_bad_width
        $error("max_pool_2x2_stream: IMG_Width must be even and >= 2");
    end
    if ((IMG_Height < 2) || ((IMG_Height % 2) != 0)) begin : g_bad_height
        $error("max_pool_2x2_stream: IMG_Height must be even and >= 2");
    end

    logic [ColW-1:0]      col_q, col_d;
    logic [RowW-1:0]      row_q, row_d;
    logic [Datawidth-1:0] pair_q, pair_d;
    logic [Datawidth-1:0] out_q, out_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic [Datawidth-1:0] line_buf_q [HalfW];

    logic                 col_last, row_last;
    logic                 lb_we;
    logic [IdxW-1:0]      lb_idx;
    logic [Datawidth-1:0] pair_max;

    function automatic logic [Datawidth-1:0] max_f(input logic [Datawidth-1:0] a,
                                                   input logic [Datawidth-1:0] b);
        if (SIGNED) begin
            return ($signed(a) > $signed(b)) ? a : b;
        end
        return (a > b) ? a : b;
    endfunction

    // Next-state: raster counters, pair register, line-buffer write and pooled output.
    always_comb begin
        col_last = (col_q == ColW'(IMG_Width - 1));
        row_last = (row_q == RowW'(IMG_Height - 1));
        lb_idx   = IdxW'(col_q >> 1);
        pair_max = max_f(pair_q, In);
        col_d    = col_q;
        row_d    = row_q;
        pair_d   = pair_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        lb_we    = 1'b0;
        if (valid_in) begin
            col_d = col_last ? '0 : col_q + ColW'(1);
            if (col_last) begin
                row_d = row_last ? '0 : row_q + RowW'(1);
            end
            if (!col_q[0]) begin
                pair_d = In;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_d   = max_f(line_buf_q[lb_idx], pair_max);
                valid_d = 1'b1;
                done_d  = col_last && row_last;
            end
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            pair_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            pair_q  <= pair_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Line buffer needs no reset: every entry is rewritten on each even row before use.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf_q[lb_idx] <= pair_max;
        end
    end

    assign valid_out  = valid_q;
    assign Out        = out_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Self-checking bench for max_pool_2x2_stream: signed 4x4, unsigned 4x4 and signed 8x2 instances
// share one input stream; outputs are compared against a frame-level pooling model.
module tb_max_pool_2x2_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vin = 1'b0;
    logic [31:0] din = '0;

    logic        vo_a, vo_b, vo_c, fd_a, fd_b, fd_c;
    logic [31:0] out_a, out_b, out_c;

    max_pool_2x2_stream #(.IMG_Width(4), .IMG_Height(4), .Datawidth(32), .SIGNED(1'b1)) dut_a (
        .clk(clk), .rst(rst), .valid_in(vin), .In(din),
        .valid_out(vo_a), .Out(out_a), .frame_done(fd_a));
    max_pool_2x2_stream #(.IMG_Width(4), .IMG_Height(4), .Datawidth(32), .SIGNED(1'b0)) dut_b (
        .clk(clk), .rst(rst), .valid_in(vin), .In(din),
        .valid_out(vo_b), .Out(out_b), .frame_done(fd_b));
    max_pool_2x2_stream #(.IMG_Width(8), .IMG_Height(2), .Datawidth(32), .SIGNED(1'b1)) dut_c (
        .clk(clk), .rst(rst), .valid_in(vin), .In(din),
        .valid_out(vo_c), .Out(out_c), .frame_done(fd_c));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] v;
        logic        d;
        int          c;
    } ev_t;

    ev_t         obs_a[$];
    ev_t         obs_b[$];
    ev_t         obs_c[$];
    ev_t         exp_q[$];
    logic [31:0] px[$];
    int          dcyc[$];
    int          stray = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Record every output pulse with the cycle it was seen in; count frame_done without valid_out.
    always @(negedge clk) begin
        if (vo_a === 1'b1) obs_a.push_back(ev_t'{out_a, fd_a, cyc});
        if (vo_b === 1'b1) obs_b.push_back(ev_t'{out_b, fd_b, cyc});
        if (vo_c === 1'b1) obs_c.push_back(ev_t'{out_c, fd_c, cyc});
        if ((fd_a === 1'b1 && vo_a !== 1'b1) || (fd_b === 1'b1 && vo_b !== 1'b1) ||
            (fd_c === 1'b1 && vo_c !== 1'b1)) stray <= stray + 1;
    end

    function automatic logic [31:0] mx(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        if (sgn) return ($signed(a) >= $signed(b)) ? a : b;
        return (a >= b) ? a : b;
    endfunction

    // Reference: split px into whole frames, take the max of each 2x2 window; a window's output
    // is due one cycle after the pixel at its bottom-right corner was presented.
    function automatic void build_exp(input int w, input int h, input bit sgn);
        int nfr;
        int base;
        logic [31:0] m;
        exp_q.delete();
        nfr = px.size() / (w * h);
        for (int f = 0; f < nfr; f++) begin
            base = f * w * h;
            for (int r = 0; r < h / 2; r++) begin
                for (int c = 0; c < w / 2; c++) begin
                    m = mx(mx(px[base + 2*r*w + 2*c], px[base + 2*r*w + 2*c + 1], sgn),
                           mx(px[base + (2*r+1)*w + 2*c], px[base + (2*r+1)*w + 2*c + 1], sgn),
                           sgn);
                    exp_q.push_back(ev_t'{m, (r == h/2 - 1) && (c == w/2 - 1),
                                          dcyc[base + (2*r+1)*w + 2*c + 1] + 1});
                end
            end
        end
    endfunction

    task automatic reset_all();
        @(negedge clk);
        rst = 1'b1;
        vin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        obs_a.delete();
        obs_b.delete();
        obs_c.delete();
        px.delete();
        dcyc.delete();
    endtask

    // Present px with 0..max_gap idle cycles before each pixel, then let the pipeline drain.
    task automatic drive(input int max_gap);
        for (int i = 0; i < px.size(); i++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                @(negedge clk);
                vin = 1'b0;
            end
            @(negedge clk);
            vin = 1'b1;
            din = px[i];
            dcyc.push_back(cyc);
        end
        @(negedge clk);
        vin = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vin = 1'b1;
            din = $urandom;
            @(negedge clk);
            n_checks++;
            if ({vo_a, fd_a, out_a, vo_b, fd_b, out_b, vo_c, fd_c, out_c} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got a=%b/%b/%h b=%b/%b/%h c=%b/%b/%h expected all 0",
                         vo_a, fd_a, out_a, vo_b, fd_b, out_b, vo_c, fd_c, out_c);
            end
        end
        vin = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int want[$] = '{5, 7, 13, 15};
        int s0;
        reset_all();
        s0 = stray;
        for (int i = 0; i < 16; i++) px.push_back(32'(i));
        drive(0);
        build_exp(4, 4, 1'b1);
        n_checks++;
        if (obs_a.size() != 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d pulses expected 4", obs_a.size());
        end
        for (int i = 0; i < 4 && i < obs_a.size(); i++) begin
            n_checks++;
            if (obs_a[i].v !== 32'(want[i]) || obs_a[i].d !== (i == 3) ||
                obs_a[i].c !== exp_q[i].c) begin
                n_fail++;
                $display("FAIL basic_out[%0d]: got val=%0d done=%b cyc=%0d expected val=%0d done=%b cyc=%0d",
                         i, obs_a[i].v, obs_a[i].d, obs_a[i].c, want[i], (i == 3), exp_q[i].c);
            end
        end
        n_checks++;
        if (stray != s0) begin
            n_fail++;
            $display("FAIL basic_stray_done: got %0d stray frame_done expected 0", stray - s0);
        end
    endtask

    task automatic test_compare();
        reset_all();
        px = '{32'hFFFFFFFF, 32'd3, 32'd0, 32'd0, 32'd2, 32'd0, 32'd0, 32'd0,
               32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        drive(0);
        n_checks++;
        if (obs_a.size() == 0 || obs_a[0].v !== 32'd3) begin
            n_fail++;
            $display("FAIL cmp_signed: got %h (%0d pulses) expected 00000003",
                     obs_a.size() ? obs_a[0].v : 32'hx, obs_a.size());
        end
        n_checks++;
        if (obs_b.size() == 0 || obs_b[0].v !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL cmp_unsigned: got %h (%0d pulses) expected ffffffff",
                     obs_b.size() ? obs_b[0].v : 32'hx, obs_b.size());
        end
        reset_all();
        for (int i = 0; i < 16; i++) px.push_back(32'h80000000);
        drive(1);
        n_checks++;
        if (obs_a.size() != 4 || obs_a[0].v !== 32'h80000000 || obs_a[3].v !== 32'h80000000) begin
            n_fail++;
            $display("FAIL cmp_most_negative: got %h (%0d pulses) expected 80000000 x4",
                     obs_a.size() ? obs_a[0].v : 32'hx, obs_a.size());
        end
    endtask

    task automatic test_gaps();
        reset_all();
        for (int i = 0; i < 16; i++) px.push_back(32'(i));
        drive(3);
        build_exp(4, 4, 1'b1);
        n_checks++;
        if (obs_a.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL gaps_count: got %0d pulses expected %0d", obs_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
            n_checks++;
            if (obs_a[i].v !== exp_q[i].v || obs_a[i].d !== exp_q[i].d ||
                obs_a[i].c !== exp_q[i].c) begin
                n_fail++;
                $display("FAIL gaps_out[%0d]: got val=%0d done=%b cyc=%0d expected val=%0d done=%b cyc=%0d",
                         i, obs_a[i].v, obs_a[i].d, obs_a[i].c, exp_q[i].v, exp_q[i].d, exp_q[i].c);
            end
        end
    endtask

    task automatic test_reset_mid();
        int want[$] = '{5, 7, 13, 15};
        reset_all();
        for (int i = 0; i < 5; i++) px.push_back(32'(i));
        drive(0);
        // Sixth pixel (the bottom-right of the first window) arrives together with reset.
        @(negedge clk);
        rst = 1'b1;
        vin = 1'b1;
        din = 32'd5;
        @(negedge clk);
        rst = 1'b0;
        vin = 1'b0;
        n_checks++;
        if ({vo_a, fd_a, out_a} !== '0) begin
            n_fail++;
            $display("FAIL midrst_after_reset: got v=%b d=%b out=%h expected 0/0/0", vo_a, fd_a, out_a);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs_a.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_partial_frame: got %0d pulses expected 0", obs_a.size());
        end
        obs_a.delete();
        px.delete();
        dcyc.delete();
        for (int i = 0; i < 16; i++) px.push_back(32'(i));
        drive(0);
        n_checks++;
        if (obs_a.size() != 4) begin
            n_fail++;
            $display("FAIL midrst_count: got %0d pulses expected 4", obs_a.size());
        end
        for (int i = 0; i < 4 && i < obs_a.size(); i++) begin
            n_checks++;
            if (obs_a[i].v !== 32'(want[i])) begin
                n_fail++;
                $display("FAIL midrst_out[%0d]: got %0d expected %0d", i, obs_a[i].v, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int want[$] = '{5, 7, 13, 15, 15, 13, 7, 5};
        int dones;
        reset_all();
        for (int i = 0; i < 16; i++) px.push_back(32'(i));
        for (int i = 0; i < 16; i++) px.push_back(32'(15 - i));
        drive(0);
        n_checks++;
        if (obs_a.size() != 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pulses expected 8", obs_a.size());
        end
        dones = 0;
        for (int i = 0; i < 8 && i < obs_a.size(); i++) begin
            dones += int'(obs_a[i].d);
            n_checks++;
            if (obs_a[i].v !== 32'(want[i])) begin
                n_fail++;
                $display("FAIL b2b_out[%0d]: got %0d expected %0d", i, obs_a[i].v, want[i]);
            end
        end
        n_checks++;
        if (dones != 2) begin
            n_fail++;
            $display("FAIL b2b_frame_done: got %0d pulses expected 2", dones);
        end
    endtask

    task automatic test_wide();
        reset_all();
        for (int r = 0; r < 2; r++) for (int c = 0; c < 8; c++) px.push_back(32'(c));
        drive(0);
        n_checks++;
        if (obs_c.size() != 4) begin
            n_fail++;
            $display("FAIL wide_count: got %0d pulses expected 4", obs_c.size());
        end
        for (int i = 0; i < 4 && i < obs_c.size(); i++) begin
            n_checks++;
            if (obs_c[i].v !== 32'(2 * i + 1) || obs_c[i].d !== (i == 3)) begin
                n_fail++;
                $display("FAIL wide_out[%0d]: got val=%0d done=%b expected val=%0d done=%b",
                         i, obs_c[i].v, obs_c[i].d, 2 * i + 1, (i == 3));
            end
        end
    endtask

    task automatic test_random();
        int s0;
        reset_all();
        s0 = stray;
        // Three 16-pixel frames: whole frames for every instance geometry.
        for (int i = 0; i < 48; i++) begin
            case ($urandom_range(3, 0))
                0:       px.push_back(32'h80000000 + $urandom_range(3, 0));
                1:       px.push_back(32'hFFFFFFF0 + $urandom_range(15, 0));
                default: px.push_back($urandom);
            endcase
        end
        drive(2);
        build_exp(4, 4, 1'b1);
        n_checks++;
        if (obs_a.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_signed_count: got %0d expected %0d", obs_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
            n_checks++;
            if (obs_a[i].v !== exp_q[i].v || obs_a[i].d !== exp_q[i].d ||
                obs_a[i].c !== exp_q[i].c) begin
                n_fail++;
                $display("FAIL rand_signed[%0d]: got val=%h done=%b cyc=%0d expected val=%h done=%b cyc=%0d",
                         i, obs_a[i].v, obs_a[i].d, obs_a[i].c, exp_q[i].v, exp_q[i].d, exp_q[i].c);
            end
        end
        build_exp(4, 4, 1'b0);
        n_checks++;
        if (obs_b.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_unsigned_count: got %0d expected %0d", obs_b.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_b.size(); i++) begin
            n_checks++;
            if (obs_b[i].v !== exp_q[i].v || obs_b[i].d !== exp_q[i].d ||
                obs_b[i].c !== exp_q[i].c) begin
                n_fail++;
                $display("FAIL rand_unsigned[%0d]: got val=%h done=%b cyc=%0d expected val=%h done=%b cyc=%0d",
                         i, obs_b[i].v, obs_b[i].d, obs_b[i].c, exp_q[i].v, exp_q[i].d, exp_q[i].c);
            end
        end
        build_exp(8, 2, 1'b1);
        n_checks++;
        if (obs_c.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_wide_count: got %0d expected %0d", obs_c.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_c.size(); i++) begin
            n_checks++;
            if (obs_c[i].v !== exp_q[i].v || obs_c[i].d !== exp_q[i].d ||
                obs_c[i].c !== exp_q[i].c) begin
                n_fail++;
                $display("FAIL rand_wide[%0d]: got val=%h done=%b cyc=%0d expected val=%h done=%b cyc=%0d",
                         i, obs_c[i].v, obs_c[i].d, obs_c[i].c, exp_q[i].v, exp_q[i].d, exp_q[i].c);
            end
        end
        n_checks++;
        if (stray != s0) begin
            n_fail++;
            $display("FAIL rand_stray_done: got %0d stray frame_done expected 0", stray - s0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_compare();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        test_wide();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
